// File: rtl/dp_be_ram_ctl_if.sv
// Port bundle for dp_be_ram_ctl: two byte-enable request ports
// plus the ready flag and per-port read results.
interface dp_be_ram_ctl_if #(
  parameter int W = 256,
  parameter int D = 64
);
  localparam int NB = W / 8;
  localparam int AW = $clog2(D);

  logic          rdy;
  logic          ena;
  logic [AW-1:0] addra;
  logic [NB-1:0] wea;
  logic [W-1:0]  dina;
  logic [W-1:0]  douta;
  logic          valida;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [NB-1:0] web;
  logic [W-1:0]  dinb;
  logic [W-1:0]  doutb;
  logic          validb;

  modport master (
    input  rdy,
    output ena, addra, wea, dina,
    input  douta, valida,
    output enb, addrb, web, dinb,
    input  doutb, validb
  );

  modport slave (
    output rdy,
    input  ena, addra, wea, dina,
    output douta, valida,
    input  enb, addrb, web, dinb,
    output doutb, validb
  );
endinterface

// File: rtl/dp_be_ram_ctl.sv
// Single-clock true dual-port byte-enable RAM with zero-fill after reset.
// Optional collision flags: define DP_BE_RAM_COLLISION_DET_EN.
module dp_be_ram_ctl #(
  parameter int W        = 256,
  parameter int D        = 64,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic clk,
  input  logic rst,
`ifdef DP_BE_RAM_COLLISION_DET_EN
  output logic coll,
  output logic coll_seen,
`endif
  dp_be_ram_ctl_if.slave bus
);
  localparam int NB = W / 8;
  localparam int AW = $clog2(D);
  localparam logic [AW-1:0] LAST  = AW'(D - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(D);

  typedef enum logic {FILL, READY} state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nx;
  logic          fill_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fill_we  = 1'b0;
    unique case (state)
      FILL: begin
        fill_we = 1'b1;
        cnt_nx  = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      end
      READY: begin
        state_nx = READY;
      end
    endcase
  end

  assign bus.rdy = (state == READY);

  function automatic logic [W-1:0] merge(
    input logic [W-1:0]  base,
    input logic [W-1:0]  din,
    input logic [NB-1:0] be
  );
    logic [W-1:0] r;
    r = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    end
    return r;
  endfunction

  logic [W-1:0] mem [D];

  logic          acc_a, acc_b;
  logic          ok_a, ok_b;
  logic          wr_a, wr_b;
  logic          same;
  logic [NB-1:0] be_a, be_b;
  logic [NB-1:0] a_on_b, b_on_a;
  logic [W-1:0]  old_a, old_b;
  logic [W-1:0]  fin_a, fin_b;
  logic [W-1:0]  rd_a, rd_b;

  assign acc_a = bus.rdy & bus.ena;
  assign acc_b = bus.rdy & bus.enb;
  assign ok_a  = {1'b0, bus.addra} < DEPTH;
  assign ok_b  = {1'b0, bus.addrb} < DEPTH;
  assign wr_a  = acc_a & ok_a & (|bus.wea);
  assign wr_b  = acc_b & ok_b & (|bus.web);
  assign same  = (bus.addra == bus.addrb);

  assign be_a   = wr_a ? bus.wea : '0;
  assign a_on_b = same ? be_a : '0;
  assign b_on_a = (wr_b & same) ? bus.web : '0;
  // Port A owns any byte it writes; B only fills the rest
  assign be_b   = wr_b ? (bus.web & ~a_on_b) : '0;

  assign old_a = ok_a ? mem[bus.addra] : '0;
  assign old_b = ok_b ? mem[bus.addrb] : '0;

  assign fin_a = merge(merge(old_a, bus.dinb, b_on_a), bus.dina, be_a);
  assign fin_b = merge(merge(old_b, bus.dinb, be_b), bus.dina, a_on_b);

  assign rd_a = (RDW_MODE != 0) ? fin_a : old_a;
  assign rd_b = (RDW_MODE != 0) ? fin_b : old_b;

  always_ff @(posedge clk) begin
    if (fill_we) mem[cnt] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
      if (be_b[i]) mem[bus.addrb][8*i +: 8] <= bus.dinb[8*i +: 8];
    end
  end

  logic         va1, vb1;
  logic [W-1:0] da1, db1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va1 <= 1'b0;
      vb1 <= 1'b0;
      da1 <= '0;
      db1 <= '0;
    end else begin
      va1 <= acc_a;
      vb1 <= acc_b;
      if (acc_a) da1 <= rd_a;
      if (acc_b) db1 <= rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic         va2, vb2;
      logic [W-1:0] da2, db2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          va2 <= 1'b0;
          vb2 <= 1'b0;
          da2 <= '0;
          db2 <= '0;
        end else begin
          va2 <= va1;
          vb2 <= vb1;
          if (va1) da2 <= da1;
          if (vb1) db2 <= db1;
        end
      end

      assign bus.valida = va2;
      assign bus.validb = vb2;
      assign bus.douta  = da2;
      assign bus.doutb  = db2;
    end else begin : g_noreg
      assign bus.valida = va1;
      assign bus.validb = vb1;
      assign bus.douta  = da1;
      assign bus.doutb  = db1;
    end
  endgenerate

`ifdef DP_BE_RAM_COLLISION_DET_EN
  logic c_now, c1, c2;

  assign c_now = acc_a & acc_b & same
               & ((|bus.wea) | (|bus.web));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1        <= 1'b0;
      c2        <= 1'b0;
      coll_seen <= 1'b0;
    end else begin
      c1        <= c_now;
      c2        <= c1;
      coll_seen <= coll_seen | c_now;
    end
  end

  assign coll = (OUT_REG != 0) ? c2 : c1;
`endif
endmodule

// File: tb/tb_dp_be_ram_ctl.sv
// Directed bench: u1 is write-first/latency 1, u2 read-first/latency 2;
// both see identical stimulus.
module tb_dp_be_ram_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        enb = 1'b0;
  logic [5:0]  addra = '0;
  logic [5:0]  addrb = '0;
  logic [3:0]  wea = '0;
  logic [3:0]  web = '0;
  logic [31:0] dina = '0;
  logic [31:0] dinb = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dp_be_ram_ctl_if #(.W(32), .D(64)) i1 ();
  dp_be_ram_ctl_if #(.W(32), .D(64)) i2 ();

  assign i1.ena = ena;
  assign i1.addra = addra;
  assign i1.wea = wea;
  assign i1.dina = dina;
  assign i1.enb = enb;
  assign i1.addrb = addrb;
  assign i1.web = web;
  assign i1.dinb = dinb;
  assign i2.ena = ena;
  assign i2.addra = addra;
  assign i2.wea = wea;
  assign i2.dina = dina;
  assign i2.enb = enb;
  assign i2.addrb = addrb;
  assign i2.web = web;
  assign i2.dinb = dinb;

`ifdef DP_BE_RAM_COLLISION_DET_EN
  logic coll1, cs1, coll2, cs2;
`endif

  dp_be_ram_ctl #(.W(32), .D(64), .RDW_MODE(1), .OUT_REG(0)) u1 (
    .clk(clk),
    .rst(rst),
`ifdef DP_BE_RAM_COLLISION_DET_EN
    .coll(coll1),
    .coll_seen(cs1),
`endif
    .bus(i1)
  );

  dp_be_ram_ctl #(.W(32), .D(64), .RDW_MODE(0), .OUT_REG(1)) u2 (
    .clk(clk),
    .rst(rst),
`ifdef DP_BE_RAM_COLLISION_DET_EN
    .coll(coll2),
    .coll_seen(cs2),
`endif
    .bus(i2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0;
    enb = 1'b0;
    wea = '0;
    web = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    total++;
    if (i1.rdy !== 1'b0) begin
      bad++;
      $display("FAIL rst_rdy got=%b exp=0", i1.rdy);
    end
    total++;
    if ({i1.valida, i1.validb, i2.valida, i2.validb} !== 4'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b%b%b%b exp=0000",
               i1.valida, i1.validb, i2.valida, i2.validb);
    end
    total++;
    if ({i1.douta, i1.doutb} !== 64'h0) begin
      bad++;
      $display("FAIL rst_dout got=%h %h exp=0", i1.douta, i1.doutb);
    end
`ifdef DP_BE_RAM_COLLISION_DET_EN
    total++;
    if ({coll1, cs1, coll2, cs2} !== 4'b0) begin
      bad++;
      $display("FAIL rst_coll got=%b%b%b%b exp=0000", coll1, cs1, coll2, cs2);
    end
`endif
    rst = 1'b0;
    ena = 1'b1;
    addra = 6'd0;
    for (int i = 0; i < 63; i++) step();
    total++;
    if (i1.rdy !== 1'b0 || i2.rdy !== 1'b0) begin
      bad++;
      $display("FAIL fill_rdy63 got=%b%b exp=00", i1.rdy, i2.rdy);
    end
    total++;
    if (i1.valida !== 1'b0) begin
      bad++;
      $display("FAIL fill_ignore got=%b exp=0", i1.valida);
    end
    step();
    total++;
    if (i1.rdy !== 1'b1 || i2.rdy !== 1'b1) begin
      bad++;
      $display("FAIL fill_rdy64 got=%b%b exp=11", i1.rdy, i2.rdy);
    end
    total++;
    if (i1.valida !== 1'b0) begin
      bad++;
      $display("FAIL fill_last_ignore got=%b exp=0", i1.valida);
    end
  endtask

  task automatic test_fill_zero();
    logic [5:0] ad [3];
    ad[0] = 6'd0;
    ad[1] = 6'd31;
    ad[2] = 6'd63;
    for (int k = 0; k < 3; k++) begin
      ena = 1'b1;
      wea = '0;
      addra = ad[k];
      step();
      total++;
      if (i1.valida !== 1'b1 || i1.douta !== 32'h0) begin
        bad++;
        $display("FAIL fill_rd%0d got=%b/%h exp=1/0", ad[k], i1.valida, i1.douta);
      end
    end
    idle();
    step();
    total++;
    if (i1.valida !== 1'b0) begin
      bad++;
      $display("FAIL fill_pulse got=%b exp=0", i1.valida);
    end
    step();
  endtask

  task automatic test_byte_write();
    ena = 1'b1;
    addra = 6'd5;
    wea = 4'b1111;
    dina = 32'hAABBCCDD;
    step();
    total++;
    if (i1.douta !== 32'hAABBCCDD || i1.valida !== 1'b1) begin
      bad++;
      $display("FAIL bw_wf1 got=%b/%h exp=1/aabbccdd", i1.valida, i1.douta);
    end
    wea = 4'b0101;
    dina = 32'h11223344;
    step();
    total++;
    if (i1.douta !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL bw_wf2 got=%h exp=aa22cc44", i1.douta);
    end
    wea = 4'b0000;
    step();
    total++;
    if (i1.douta !== 32'hAA22CC44) begin
      bad++;
      $display("FAIL bw_read got=%h exp=aa22cc44", i1.douta);
    end
    total++;
    if (i2.douta !== 32'hAABBCCDD || i2.valida !== 1'b1) begin
      bad++;
      $display("FAIL bw_rf_old got=%b/%h exp=1/aabbccdd", i2.valida, i2.douta);
    end
    idle();
    step();
    total++;
    if (i2.douta !== 32'hAA22CC44 || i2.valida !== 1'b1) begin
      bad++;
      $display("FAIL bw_lat2 got=%b/%h exp=1/aa22cc44", i2.valida, i2.douta);
    end
    total++;
    if (i1.valida !== 1'b0) begin
      bad++;
      $display("FAIL bw_pulse got=%b exp=0", i1.valida);
    end
    step();
  endtask

  task automatic test_rdw_cross();
    ena = 1'b1;
    addra = 6'd3;
    wea = 4'b0011;
    dina = 32'hDEADBEEF;
    enb = 1'b1;
    addrb = 6'd3;
    web = 4'b0000;
    step();
    total++;
    if (i1.doutb !== 32'h0000BEEF || i1.validb !== 1'b1) begin
      bad++;
      $display("FAIL rdw1_b got=%b/%h exp=1/0000beef", i1.validb, i1.doutb);
    end
    total++;
    if (i1.douta !== 32'h0000BEEF) begin
      bad++;
      $display("FAIL rdw1_a got=%h exp=0000beef", i1.douta);
    end
    idle();
    step();
    total++;
    if (i2.doutb !== 32'h0 || i2.validb !== 1'b1) begin
      bad++;
      $display("FAIL rdw0_b got=%b/%h exp=1/0", i2.validb, i2.doutb);
    end
    total++;
    if (i1.validb !== 1'b0) begin
      bad++;
      $display("FAIL rdw_pulse got=%b exp=0", i1.validb);
    end
    ena = 1'b1;
    addra = 6'd3;
    step();
    total++;
    if (i1.douta !== 32'h0000BEEF) begin
      bad++;
      $display("FAIL rdw_store got=%h exp=0000beef", i1.douta);
    end
    idle();
    step();
  endtask

  task automatic test_collision();
    ena = 1'b1;
    addra = 6'd7;
    wea = 4'b0001;
    dina = 32'h11111111;
    enb = 1'b1;
    addrb = 6'd7;
    web = 4'b1111;
    dinb = 32'h22222222;
    step();
    total++;
    if (i1.douta !== 32'h22222211 || i1.doutb !== 32'h22222211) begin
      bad++;
      $display("FAIL coll_merge got=%h %h exp=22222211", i1.douta, i1.doutb);
    end
`ifdef DP_BE_RAM_COLLISION_DET_EN
    total++;
    if (coll1 !== 1'b1) begin
      bad++;
      $display("FAIL coll_pulse1 got=%b exp=1", coll1);
    end
`endif
    idle();
    step();
    total++;
    if (i2.douta !== 32'h0 || i2.valida !== 1'b1) begin
      bad++;
      $display("FAIL coll_rf got=%b/%h exp=1/0", i2.valida, i2.douta);
    end
`ifdef DP_BE_RAM_COLLISION_DET_EN
    total++;
    if (coll1 !== 1'b0 || cs1 !== 1'b1 || coll2 !== 1'b1) begin
      bad++;
      $display("FAIL coll_seq got=%b%b%b exp=011", coll1, cs1, coll2);
    end
`endif
    ena = 1'b1;
    addra = 6'd7;
    step();
    total++;
    if (i1.douta !== 32'h22222211) begin
      bad++;
      $display("FAIL coll_store got=%h exp=22222211", i1.douta);
    end
`ifdef DP_BE_RAM_COLLISION_DET_EN
    total++;
    if (coll2 !== 1'b0 || cs2 !== 1'b1) begin
      bad++;
      $display("FAIL coll_seq2 got=%b%b exp=01", coll2, cs2);
    end
`endif
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb;
    for (int k = 0; k < 5; k++) begin
      ena = 1'b1;
      addra = 6'(k);
      wea = 4'hF;
      dina = 32'hC0DE0000 | k;
      enb = 1'b1;
      addrb = 6'(k + 5);
      web = 4'hF;
      dinb = 32'hC0DE0000 | (k + 5);
      step();
    end
    idle();
    step();
    for (int k = 0; k < 11; k++) begin
      if (k < 10) begin
        ena = 1'b1;
        enb = 1'b1;
        addra = 6'(k);
        addrb = 6'(9 - k);
      end else begin
        idle();
      end
      step();
      if (k < 10) begin
        total++;
        if (i1.douta !== (32'hC0DE0000 | k) || i1.valida !== 1'b1) begin
          bad++;
          $display("FAIL b2b_l1 k=%0d got=%b/%h", k, i1.valida, i1.douta);
        end
      end
      if (k == 0) begin
        total++;
        if (i2.valida !== 1'b0 || i2.validb !== 1'b0) begin
          bad++;
          $display("FAIL b2b_early got=%b%b exp=00", i2.valida, i2.validb);
        end
      end else begin
        ea = 32'hC0DE0000 | (k - 1);
        eb = 32'hC0DE0000 | (10 - k);
        total++;
        if (i2.valida !== 1'b1 || i2.douta !== ea) begin
          bad++;
          $display("FAIL b2b_a k=%0d got=%b/%h exp=1/%h", k, i2.valida, i2.douta, ea);
        end
        total++;
        if (i2.validb !== 1'b1 || i2.doutb !== eb) begin
          bad++;
          $display("FAIL b2b_b k=%0d got=%b/%h exp=1/%h", k, i2.validb, i2.doutb, eb);
        end
      end
    end
    step();
    total++;
    if (i2.valida !== 1'b0 || i2.validb !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b%b exp=00", i2.valida, i2.validb);
    end
  endtask

  task automatic test_mid_reset();
    ena = 1'b1;
    addra = 6'd2;
    wea = 4'hF;
    dina = 32'hFFFFFFFF;
    step();
    wea = 4'h0;
    step();
    idle();
    rst = 1'b1;
    #1;
    total++;
    if (i2.valida !== 1'b0 || i1.valida !== 1'b0 || i1.rdy !== 1'b0) begin
      bad++;
      $display("FAIL mr_flush got=%b%b%b exp=000", i2.valida, i1.valida, i1.rdy);
    end
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 63; i++) step();
    total++;
    if (i1.rdy !== 1'b0 || i2.valida !== 1'b0) begin
      bad++;
      $display("FAIL mr_rdy63 got=%b/%b exp=0/0", i1.rdy, i2.valida);
    end
    step();
    total++;
    if (i1.rdy !== 1'b1) begin
      bad++;
      $display("FAIL mr_rdy64 got=%b exp=1", i1.rdy);
    end
    ena = 1'b1;
    addra = 6'd2;
    step();
    total++;
    if (i1.douta !== 32'h0 || i1.valida !== 1'b1) begin
      bad++;
      $display("FAIL mr_zero1 got=%b/%h exp=1/0", i1.valida, i1.douta);
    end
    idle();
    step();
    total++;
    if (i2.douta !== 32'h0 || i2.valida !== 1'b1) begin
      bad++;
      $display("FAIL mr_zero2 got=%b/%h exp=1/0", i2.valida, i2.douta);
    end
  endtask

  initial begin
    test_reset();
    test_fill_zero();
    test_byte_write();
    test_rdw_cross();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dp_be_ram_ctl.md
Name: dp_be_ram_ctl

Overview:
- Single-clock, true dual-port, byte-enable RAM with a built-in zero-fill sequencer after reset.
- Adds a selectable read-during-write mode, deterministic same-address write arbitration, an optional output pipeline stage, and read-valid tracking.
- Serves as the storage core for the FIFO and packet buffers, replacing ad-hoc dual-clock RAMs wherever both ports run on one clock.

Parameters:
- W, 256, data width in bits; must be a multiple of 8; byte lanes NB = W/8.
- D, 64, depth in words; any value >= 2; address width AW = clogb2(D).
- RDW_MODE, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new bytes merged into the read result).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  in  1  Sole clock; all logic samples on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- rdy  out  1  High when the zero-fill sequence is complete and ports accept requests.
- ena  in  1  Port A request enable.
- addra  in  AW  Port A word address.
- wea  in  NB  Port A byte write enables; all zeros = read-only access.
- dina  in  W  Port A write data.
- douta  out  W  Port A read data.
- valida  out  1  Port A read data valid pulse.
- enb  in  1  Port B request enable.
- addrb  in  AW  Port B word address.
- web  in  NB  Port B byte write enables.
- dinb  in  W  Port B write data.
- doutb  out  W  Port B read data.
- validb  out  1  Port B read data valid pulse.

Behaviour:
- Reset values (asynchronous on rst assertion):
  - rdy = 0, douta = doutb = 0, valida = validb = 0.
  - Fill counter = 0; FSM enters state FILL.
- FSM, two states:
  - FILL: writes all-zero to address cnt each cycle, cnt increments. When cnt == D-1, that write completes and the FSM moves to READY on the same edge. Occupies exactly D cycles after rst deasserts.
  - READY: rdy = 1; holds until the next reset.
- While rdy = 0, ena/enb are ignored: no write, no valid pulse.
- Accept condition: a port access is accepted on an edge where rdy = 1 and en = 1.
- Writes: byte i of the addressed word takes din[8i+:8] when we[i] = 1; all other bytes are unchanged.
- Every accepted access returns read data, including writes.
  - Latency 1 + OUT_REG cycles.
  - valid pulses high for exactly one cycle, aligned with the data.
  - dout holds its last value when valid is low.
- Read-during-write, same port and same address:
  - RDW_MODE = 0: dout returns the pre-write word.
  - RDW_MODE = 1: dout returns the pre-write word with the written bytes replaced.
- Cross-port, same cycle and same address, one port writing and the other reading: the reading port follows the same RDW_MODE rule, using the writer's enables and data.
- Both ports writing the same address in the same cycle:
  - Per byte, port A wins wherever wea[i] = 1; port B's byte is written only where wea[i] = 0 and web[i] = 1.
  - Each port's read result follows RDW_MODE using the final merged word.
- Different addresses: ports are fully independent, with no throughput loss; one access per port per cycle.
- Reset mid-operation:
  - Discards in-flight reads; no valid pulse is emitted for them.
  - Restarts FILL from address 0.
  - Memory contents are fully rezeroed before rdy rises again.
- Addresses >= D (D not a power of two): writes are dropped, reads return 0, and valid still pulses.

Optional Feature:
- Macro: DP_BE_RAM_COLLISION_DET_EN.
- Enabled:
  - Extra output port "coll" (1 bit, reset 0).
  - Pulses high for one cycle, aligned with the port A result, whenever both ports were accepted at the same address with at least one port writing.
  - Also adds a sticky output "coll_seen" (1 bit, reset 0), set on any collision and cleared only by rst.
- Disabled: neither port exists, no collision comparison logic is generated, and behaviour is otherwise identical.

Test Plan:
- Reset fill, D=64: deassert rst and probe rdy → rdy rises exactly 64 cycles later. Then read addresses 0, 31 and 63 → 0, with each valid high 1 cycle after the request (OUT_REG=0).
- Byte write, W=32: write 0xAABBCCDD to addr 5 with wea=4'b1111, then 0x11223344 with wea=4'b0101. Read addr 5 → 0xAA22CC44.
- RDW_MODE=1, W=32: addr 3 holds 0. Port A writes 0xDEADBEEF with wea=4'b0011 while port B reads addr 3 in the same cycle → doutb = 0x0000BEEF. With RDW_MODE=0 → doutb = 0x00000000.
- Write collision, W=32: same cycle, A writes 0x11111111 with wea=4'b0001 and B writes 0x22222222 with web=4'b1111, both to addr 7. Read addr 7 → 0x22222211; coll pulses once if DP_BE_RAM_COLLISION_DET_EN is defined.
- OUT_REG=1: back-to-back reads on both ports at addresses 0..9 → valid high every cycle starting 2 cycles after the first request, with data in order.
- Mid-operation reset: write 0xFF.. to addr 2, issue a read, then pulse rst on the next cycle → no valid pulse for that read, rdy low for 64 cycles, and a subsequent read of addr 2 → 0.
